// File: rtl/cmos_in_capture_ctrl.sv
// Frame-level capture sequencer between the CMOS-in stream formatter and its input FIFO.
// Forwards whole frames only, drops the rest of a frame on FIFO overflow, and keeps stats.
module cmos_in_capture_ctrl #(
    parameter int unsigned PIXELS_WIDTH = 16,
    parameter int unsigned CNT_WIDTH    = 16,
    parameter int unsigned GEO_WIDTH    = 12
) (
    input  logic                    VID_IN_CLK,
    input  logic                    VID_IN_RST,
    input  logic                    CTRL_ENABLE,
    input  logic                    CTRL_SINGLE,
    input  logic                    CTRL_START,
    input  logic                    CTRL_CLR,
    input  logic [PIXELS_WIDTH+1:0] IN_DATA,
    input  logic                    IN_WR_EN,
    input  logic                    FIFO_FULL,
    output logic [PIXELS_WIDTH+1:0] FIFO_WR_DATA,
    output logic                    FIFO_WR_EN,
    output logic                    STAT_BUSY,
    output logic                    STAT_FRAME_DONE,
    output logic                    STAT_OVERFLOW,
    output logic [CNT_WIDTH-1:0]    STAT_FRAMES,
    output logic [CNT_WIDTH-1:0]    STAT_DROPS,
    output logic [GEO_WIDTH-1:0]    STAT_LINE_PIXELS,
    output logic [GEO_WIDTH-1:0]    STAT_FRAME_LINES
);

    localparam int unsigned W = PIXELS_WIDTH + 2;
    localparam logic [GEO_WIDTH-1:0] GEO_MAX = '1;

    typedef enum logic [1:0] {StIdle, StWaitSof, StCapture, StDrop} state_t;

    state_t                 state_q, state_d;
    logic                   start_pend_q;
    logic [GEO_WIDTH-1:0]   pix_cnt_q, line_cnt_q;
    logic                   is_sof, is_eol, go;
    logic                   do_write, do_drop, do_done;
    logic [GEO_WIDTH-1:0]   pix_base, line_base, pix_inc, line_inc;

    function automatic logic [GEO_WIDTH-1:0] sat_inc(input logic [GEO_WIDTH-1:0] v);
        return (v == GEO_MAX) ? v : v + 1'b1;
    endfunction

    assign is_sof    = IN_WR_EN & IN_DATA[W-1];
    assign is_eol    = IN_DATA[W-2];
    assign go        = CTRL_ENABLE & (~CTRL_SINGLE | start_pend_q);
    assign STAT_BUSY = (state_q != StIdle);

    // A written sof restarts the line/frame geometry before this word is counted.
    assign pix_base  = is_sof ? '0 : pix_cnt_q;
    assign line_base = is_sof ? '0 : line_cnt_q;
    assign pix_inc   = sat_inc(pix_base);
    assign line_inc  = sat_inc(line_base);

    always_comb begin
        state_d  = state_q;
        do_write = 1'b0;
        do_drop  = 1'b0;
        do_done  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) state_d = StWaitSof;
            end
            StWaitSof: begin
                if (!CTRL_ENABLE) begin
                    state_d = StIdle;
                end else if (is_sof) begin
                    if (FIFO_FULL) begin
                        do_drop = 1'b1;
                        state_d = StDrop;
                    end else begin
                        do_write = 1'b1;
                        state_d  = StCapture;
                    end
                end
            end
            StCapture: begin
                if (IN_WR_EN && FIFO_FULL) begin
                    do_drop = 1'b1;
                    state_d = StDrop;
                end else if (is_sof) begin
                    // Enable/mode changes take effect only at this frame boundary.
                    do_done = 1'b1;
                    if (go && !CTRL_SINGLE) do_write = 1'b1;
                    else                    state_d  = StIdle;
                end else if (IN_WR_EN) begin
                    do_write = 1'b1;
                end
            end
            StDrop: begin
                if (is_sof) begin
                    if (!go) begin
                        state_d = StIdle;
                    end else if (!FIFO_FULL) begin
                        do_write = 1'b1;
                        state_d  = StCapture;
                    end else begin
                        do_drop = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge VID_IN_CLK) begin
        if (VID_IN_RST) begin
            state_q          <= StIdle;
            start_pend_q     <= 1'b0;
            pix_cnt_q        <= '0;
            line_cnt_q       <= '0;
            FIFO_WR_DATA     <= '0;
            FIFO_WR_EN       <= 1'b0;
            STAT_FRAME_DONE  <= 1'b0;
            STAT_OVERFLOW    <= 1'b0;
            STAT_FRAMES      <= '0;
            STAT_DROPS       <= '0;
            STAT_LINE_PIXELS <= '0;
            STAT_FRAME_LINES <= '0;
        end else begin
            state_q         <= state_d;
            FIFO_WR_EN      <= do_write;
            STAT_FRAME_DONE <= do_done;
            if (do_write) FIFO_WR_DATA <= IN_DATA;

            if (CTRL_START)                               start_pend_q <= 1'b1;
            else if (do_write && is_sof && CTRL_SINGLE)   start_pend_q <= 1'b0;

            if (CTRL_CLR) begin
                STAT_OVERFLOW <= 1'b0;
                STAT_FRAMES   <= '0;
                STAT_DROPS    <= '0;
            end else begin
                if (do_drop) begin
                    STAT_OVERFLOW <= 1'b1;
                    STAT_DROPS    <= STAT_DROPS + 1'b1;
                end
                if (do_done) STAT_FRAMES <= STAT_FRAMES + 1'b1;
            end

            if (do_done) STAT_FRAME_LINES <= line_cnt_q;

            if (do_write) begin
                if (is_eol) begin
                    STAT_LINE_PIXELS <= pix_inc;
                    pix_cnt_q        <= '0;
                    line_cnt_q       <= line_inc;
                end else begin
                    pix_cnt_q        <= pix_inc;
                    line_cnt_q       <= line_base;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_in_capture_ctrl.sv
// Self-checking bench for cmos_in_capture_ctrl: directed table, hand-written frame sequences,
// and randomized framed traffic checked each cycle against a behavioural model.
module tb_cmos_in_capture_ctrl;

    localparam int PW   = 16;
    localparam int CW   = 16;
    localparam int GW   = 12;
    localparam int W    = PW + 2;
    localparam int GMAX = (1 << GW) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, sg, st, clr, wr, full;
    logic [W-1:0]  din;
    logic [W-1:0]  wr_data;
    logic          wr_en, busy, done, ovf;
    logic [CW-1:0] frames, drops;
    logic [GW-1:0] lpix, flines;

    cmos_in_capture_ctrl #(
        .PIXELS_WIDTH (PW),
        .CNT_WIDTH    (CW),
        .GEO_WIDTH    (GW)
    ) dut (
        .VID_IN_CLK       (clk),
        .VID_IN_RST       (rst),
        .CTRL_ENABLE      (en),
        .CTRL_SINGLE      (sg),
        .CTRL_START       (st),
        .CTRL_CLR         (clr),
        .IN_DATA          (din),
        .IN_WR_EN         (wr),
        .FIFO_FULL        (full),
        .FIFO_WR_DATA     (wr_data),
        .FIFO_WR_EN       (wr_en),
        .STAT_BUSY        (busy),
        .STAT_FRAME_DONE  (done),
        .STAT_OVERFLOW    (ovf),
        .STAT_FRAMES      (frames),
        .STAT_DROPS       (drops),
        .STAT_LINE_PIXELS (lpix),
        .STAT_FRAME_LINES (flines)
    );

    int checks = 0;
    int errors = 0;
    int n_wr   = 0;
    int n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: frame-level flags plus plain counters.
    bit            m_waiting, m_capturing, m_dropping, m_pend;
    int            m_pix, m_lines;
    bit            e_wr, e_done, e_ovf, e_busy;
    logic [W-1:0]  e_data;
    logic [CW-1:0] e_frames, e_drops;
    int            e_lpix, e_flines;

    function automatic int sat(input int v);
        return (v > GMAX) ? GMAX : v;
    endfunction

    task automatic model_step();
        bit sof, eol, go, wrt, drp, dn;
        sof = wr && din[W-1];
        eol = din[W-2];
        if (rst) begin
            m_waiting = 0; m_capturing = 0; m_dropping = 0; m_pend = 0;
            m_pix = 0; m_lines = 0;
            e_wr = 0; e_done = 0; e_ovf = 0; e_busy = 0; e_data = '0;
            e_frames = '0; e_drops = '0; e_lpix = 0; e_flines = 0;
            return;
        end
        go  = en && (!sg || m_pend);
        wrt = 0; drp = 0; dn = 0;
        if (m_waiting) begin
            if (!en) m_waiting = 0;
            else if (sof) begin
                m_waiting = 0;
                if (full) begin drp = 1; m_dropping = 1; end
                else begin wrt = 1; m_capturing = 1; end
            end
        end else if (m_capturing) begin
            if (wr && full) begin drp = 1; m_capturing = 0; m_dropping = 1; end
            else if (sof) begin
                dn = 1;
                if (go && !sg) wrt = 1;
                else m_capturing = 0;
            end else if (wr) wrt = 1;
        end else if (m_dropping) begin
            if (sof) begin
                if (!go) m_dropping = 0;
                else if (!full) begin wrt = 1; m_dropping = 0; m_capturing = 1; end
                else drp = 1;
            end
        end else if (go) begin
            m_waiting = 1;
        end
        e_wr   = wrt;
        e_done = dn;
        if (wrt) e_data = din;
        if (clr) begin
            e_ovf = 0; e_frames = '0; e_drops = '0;
        end else begin
            if (drp) begin e_ovf = 1; e_drops = e_drops + 1'b1; end
            if (dn) e_frames = e_frames + 1'b1;
        end
        if (dn) e_flines = m_lines;
        if (wrt) begin
            if (sof) begin m_pix = 0; m_lines = 0; end
            m_pix = sat(m_pix + 1);
            if (eol) begin e_lpix = m_pix; m_pix = 0; m_lines = sat(m_lines + 1); end
        end
        if (st) m_pend = 1;
        else if (wrt && sof && sg) m_pend = 0;
        e_busy = m_waiting || m_capturing || m_dropping;
    endtask

    task automatic compare_all();
        check("wr_en", wr_en, e_wr);
        check("wr_data", wr_data, e_data);
        check("busy", busy, e_busy);
        check("frame_done", done, e_done);
        check("overflow", ovf, e_ovf);
        check("frames", frames, e_frames);
        check("drops", drops, e_drops);
        check("line_pixels", lpix, e_lpix);
        check("frame_lines", flines, e_flines);
    endtask

    task automatic cycle(input bit cmp);
        model_step();
        @(posedge clk);
        #1;
        if (wr_en) n_wr++;
        if (done) n_done++;
        if (cmp) compare_all();
    endtask

    task automatic quiet();
        rst = 0; st = 0; clr = 0; wr = 0; full = 0; din = '0;
    endtask

    task automatic send_word(input bit s, input bit e, input bit f);
        wr   = 1;
        din  = {s, e, 16'($urandom)};
        full = f;
        cycle(1);
        wr = 0; full = 0; clr = 0;
    endtask

    task automatic send_frame(input int nl, input int ppl, input int full_at, input int en_off_at);
        int idx = 0;
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ppl; p++) begin
                if (idx == en_off_at) en = 0;
                send_word(l == 0 && p == 0, p == ppl - 1, idx == full_at);
                idx++;
            end
        end
    endtask

    task automatic start_seq(input bit single);
        quiet();
        rst = 1; en = 0; sg = single;
        cycle(1);
        rst = 0;
        n_wr = 0; n_done = 0;
    endtask

    task automatic rand_ctrl();
        full = ($urandom_range(0, 24) == 0);
        clr  = ($urandom_range(0, 79) == 0);
        st   = ($urandom_range(0, 29) == 0);
        rst  = ($urandom_range(0, 399) == 0);
        if ($urandom_range(0, 59) == 0) en = ~en;
    endtask

    typedef struct {
        bit rst, en, wr, sof, full, clr;
        bit exp_wr, exp_busy, exp_done;
        int exp_drops, exp_frames;
    } vec_t;

    vec_t tbl[13];

    initial begin
        quiet();
        en = 0; sg = 0;

        //            rst en wr sof full clr | wr busy done drops frames
        tbl[0]  = '{1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 0, 0,  0, 1, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0};
        tbl[4]  = '{0, 1, 1, 0, 0, 0,  1, 1, 0, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 1, 0,  0, 1, 0, 1, 0};
        tbl[6]  = '{0, 1, 1, 0, 0, 0,  0, 1, 0, 1, 0};
        tbl[7]  = '{0, 1, 1, 1, 1, 0,  0, 1, 0, 2, 0};
        tbl[8]  = '{0, 1, 1, 1, 0, 0,  1, 1, 0, 2, 0};
        tbl[9]  = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 2, 0};
        tbl[10] = '{0, 0, 1, 1, 0, 0,  0, 0, 1, 2, 1};
        tbl[11] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 1};
        tbl[12] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].rst; en = tbl[i].en; wr = tbl[i].wr; full = tbl[i].full;
            clr = tbl[i].clr; st = 0; sg = 0;
            din = {tbl[i].sof, 1'b0, 16'(i)};
            cycle(0);
            check($sformatf("tbl%0d_wr_en", i), wr_en, tbl[i].exp_wr);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].exp_busy);
            check($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
            check($sformatf("tbl%0d_drops", i), drops, tbl[i].exp_drops);
            check($sformatf("tbl%0d_frames", i), frames, tbl[i].exp_frames);
        end

        // Continuous 4x3 frames, enable raised on the first sof (frame 1 is missed).
        start_seq(0);
        en = 1;
        for (int f = 0; f < 4; f++) send_frame(3, 4, -1, -1);
        send_word(1, 0, 0);
        check("cont_words", n_wr, 37);
        check("cont_dones", n_done, 3);
        check("cont_frames", frames, 3);
        check("cont_line_pixels", lpix, 4);
        check("cont_frame_lines", flines, 3);

        // Single-shot: one arm pulse captures exactly one frame.
        start_seq(1);
        en = 1; st = 1;
        cycle(1);
        st = 0;
        cycle(1);
        for (int f = 0; f < 3; f++) send_frame(3, 4, -1, -1);
        check("single_words", n_wr, 12);
        check("single_frames", frames, 1);
        check("single_busy", busy, 0);

        // FIFO full for one cycle mid-frame 2.
        start_seq(0);
        en = 1;
        cycle(1);
        send_frame(3, 4, -1, -1);
        send_frame(3, 4, 5, -1);
        send_frame(3, 4, -1, -1);
        send_word(1, 0, 0);
        check("ovf_words", n_wr, 30);
        check("ovf_drops", drops, 1);
        check("ovf_flag", ovf, 1);
        check("ovf_frames", frames, 2);

        // Enable dropped mid-frame: frame completes, next sof not written.
        start_seq(0);
        en = 1;
        cycle(1);
        send_frame(3, 4, -1, 6);
        send_word(1, 0, 0);
        check("endrop_words", n_wr, 12);
        check("endrop_busy", busy, 0);
        check("endrop_frames", frames, 1);

        // Clear in the same cycle as a drop.
        start_seq(0);
        en = 1;
        cycle(1);
        send_word(1, 0, 0);
        send_word(0, 0, 0);
        clr = 1;
        send_word(0, 0, 1);
        check("clr_drops", drops, 0);
        check("clr_ovf", ovf, 0);
        check("clr_busy", busy, 1);

        // Reset mid-frame.
        start_seq(0);
        en = 1;
        cycle(1);
        send_word(1, 0, 0);
        send_word(0, 0, 0);
        send_word(0, 0, 0);
        send_word(0, 1, 0);
        send_word(0, 0, 0);
        rst = 1;
        send_word(0, 0, 0);
        rst = 0;
        check("rst_wr_en", wr_en, 0);
        check("rst_line_pixels", lpix, 0);
        check("rst_busy", busy, 0);
        en = 0;
        n_wr = 0;
        for (int i = 0; i < 3; i++) send_word(0, 0, 0);
        en = 1;
        send_word(0, 0, 0);
        send_word(0, 1, 0);
        check("rst_no_writes", n_wr, 0);
        send_word(1, 0, 0);
        check("rst_resume", n_wr, 1);

        // Geometry saturation on an over-long line.
        start_seq(0);
        en = 1;
        cycle(1);
        send_word(1, 0, 0);
        for (int i = 0; i < 4098; i++) send_word(0, 0, 0);
        send_word(0, 1, 0);
        send_word(1, 0, 0);
        check("sat_line_pixels", lpix, GMAX);
        check("sat_frame_lines", flines, 1);

        // Randomized framed traffic with sporadic full/clear/start/reset/enable changes.
        start_seq(0);
        for (int ep = 0; ep < 40; ep++) begin
            int ppl = $urandom_range(2, 6);
            int nl  = $urandom_range(1, 4);
            en = 1;
            sg = ($urandom_range(0, 3) == 0);
            for (int f = 0; f < 3; f++) begin
                for (int l = 0; l < nl; l++) begin
                    for (int p = 0; p < ppl; p++) begin
                        if ($urandom_range(0, 4) == 0) begin
                            wr = 0;
                            din = {2'b00, 16'($urandom)};
                            rand_ctrl();
                            cycle(1);
                        end
                        wr  = 1;
                        din = {(l == 0 && p == 0), (p == ppl - 1), 16'($urandom)};
                        rand_ctrl();
                        cycle(1);
                    end
                end
            end
        end
        quiet();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
